// File: rtl/aidan_mcnay_pulse_stretcher.sv
// rtl/aidan_mcnay_pulse_stretcher.sv - turns each rising edge of in into one clean out pulse
// Guarantees a minimum high width and low gap; extra edges are queued, never merged.
module aidan_mcnay_pulse_stretcher #(
    parameter int HIGH_CYCLES = 8,
    parameter int LOW_CYCLES  = 8,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_count,
    output logic              overflow
);

    localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [TW-1:0]     HIGH_LD  = TW'(HIGH_CYCLES);
    localparam logic [TW-1:0]     LOW_LD   = TW'(LOW_CYCLES);
    localparam logic [TW-1:0]     TMR_ONE  = TW'(1);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              out_q, out_d;
    logic              in_q, in_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;

    logic ev;
    logic pend_nz;
    logic tmr_last;
    logic start;

    always_comb begin
        in_d     = in;
        ev       = in & ~in_q;
        pend_nz  = (pend_q != '0);
        tmr_last = (timer_q == TMR_ONE);
        start    = (ev | pend_nz) &
                   ((state_q == ST_IDLE) | ((state_q == ST_GAP) & tmr_last));

        state_d = state_q;
        timer_d = timer_q;
        out_d   = out_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HIGH;
                    timer_d = HIGH_LD;
                    out_d   = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tmr_last) begin
                    state_d = ST_GAP;
                    timer_d = LOW_LD;
                    out_d   = 1'b0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_GAP: begin
                if (tmr_last && start) begin
                    state_d = ST_HIGH;
                    timer_d = HIGH_LD;
                    out_d   = 1'b1;
                end else if (tmr_last) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                out_d   = 1'b0;
            end
        endcase

        // A start with a queued event consumes it while any new edge takes its slot.
        if (start) begin
            if (pend_nz && !ev) begin
                pend_d = pend_q - PEND_ONE;
            end
        end else if (ev) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            out_q   <= 1'b0;
            in_q    <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            out_q   <= out_d;
            in_q    <= in_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out        = out_q;
    assign busy       = (state_q != ST_IDLE);
    assign pend_count = pend_q;
    assign overflow   = ovf_q;

endmodule
